// File: rtl/smiley_hit_edge_detector_pkg.sv
// Shared types and constants for the smiley collision path.
// The mover imports the same package to decode HitEdgeCode.
package smiley_collision_pkg;

  localparam int EDGE_LEFT   = 3;
  localparam int EDGE_TOP    = 2;
  localparam int EDGE_RIGHT  = 1;
  localparam int EDGE_BOTTOM = 0;

  typedef logic [3:0]         edge_code_t;
  typedef logic signed [10:0] coord_t;

  typedef enum logic {
    WAIT_SOF = 1'b0,
    ACCUM    = 1'b1
  } hit_state_t;

endpackage

// File: rtl/smiley_hit_edge_detector_if.sv
// Pixel-scan inputs and per-frame collision report between the scan source and the detector.
interface smiley_hit_edge_detector_if
  import smiley_collision_pkg::*;
#(
  parameter int COUNT_W = 8
);
  logic               startOfFrame;
  logic [10:0]        pixelX;
  logic [10:0]        pixelY;
  coord_t             topLeftX;
  coord_t             topLeftY;
  logic               smileyDrawingRequest;
  logic               obstacleDrawingRequest;
  logic               collision;
  edge_code_t         HitEdgeCode;
  logic [COUNT_W-1:0] hitPixelCount;

  modport master (
    output startOfFrame, pixelX, pixelY, topLeftX, topLeftY,
           smileyDrawingRequest, obstacleDrawingRequest,
    input  collision, HitEdgeCode, hitPixelCount
  );

  modport slave (
    input  startOfFrame, pixelX, pixelY, topLeftX, topLeftY,
           smileyDrawingRequest, obstacleDrawingRequest,
    output collision, HitEdgeCode, hitPixelCount
  );
endinterface

// File: rtl/smiley_edge_classifier.sv
// Combinational stage 0: pixel offset inside the smiley and which edge bands it touches.
module smiley_edge_classifier
  import smiley_collision_pkg::*;
#(
  parameter int OBJECT_WIDTH_X  = 64,
  parameter int OBJECT_HEIGHT_Y = 64,
  parameter int EDGE_MARGIN     = 8
) (
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  coord_t      topLeftX,
  input  coord_t      topLeftY,
  input  logic        smileyDrawingRequest,
  input  logic        obstacleDrawingRequest,
  output logic        hit,
  output edge_code_t  code
);

  localparam logic signed [11:0] WIDTH    = 12'(OBJECT_WIDTH_X);
  localparam logic signed [11:0] HEIGHT   = 12'(OBJECT_HEIGHT_Y);
  localparam logic signed [11:0] MARGIN   = 12'(EDGE_MARGIN);
  localparam logic signed [11:0] RIGHT_LO = 12'(OBJECT_WIDTH_X - EDGE_MARGIN);
  localparam logic signed [11:0] BOTTOM_LO = 12'(OBJECT_HEIGHT_Y - EDGE_MARGIN);

  logic signed [11:0] off_x;
  logic signed [11:0] off_y;
  logic               in_x;
  logic               in_y;

  // Sign-extend topLeft so a smiley hanging off the left/top of the screen still yields a correct offset.
  assign off_x = $signed({1'b0, pixelX}) - $signed({topLeftX[10], topLeftX});
  assign off_y = $signed({1'b0, pixelY}) - $signed({topLeftY[10], topLeftY});

  assign in_x = (off_x >= 12'sd0) && (off_x < WIDTH);
  assign in_y = (off_y >= 12'sd0) && (off_y < HEIGHT);
  assign hit  = smileyDrawingRequest && obstacleDrawingRequest;

  always_comb begin
    code = '0;
    if (hit && in_x && in_y) begin
      code[EDGE_LEFT]   = (off_x < MARGIN);
      code[EDGE_RIGHT]  = (off_x >= RIGHT_LO);
      code[EDGE_TOP]    = (off_y < MARGIN);
      code[EDGE_BOTTOM] = (off_y >= BOTTOM_LO);
    end
  end

endmodule

// File: rtl/smiley_hit_edge_detector.sv
// Accumulates smiley/obstacle overlap over a frame and reports it once per startOfFrame.
//
// state    | meaning
// ---------+------------------------------------------------------------
// WAIT_SOF | after reset; pixels ignored until the first frame boundary
// ACCUM    | OR-ing edge codes and counting hits; report+clear on each SOF
module smiley_hit_edge_detector
  import smiley_collision_pkg::*;
#(
  parameter int OBJECT_WIDTH_X  = 64,
  parameter int OBJECT_HEIGHT_Y = 64,
  parameter int EDGE_MARGIN     = 8,
  parameter int COUNT_W         = 8
) (
  input logic                  clk,
  input logic                  resetN,
  smiley_hit_edge_detector_if.slave bus
);

  localparam logic [COUNT_W-1:0] CNT_MAX = '1;

  logic               hit_s0;
  edge_code_t         code_s0;
  logic               hit_q;
  edge_code_t         code_q;

  hit_state_t         state_q, state_d;
  edge_code_t         acc_q, acc_d;
  logic               any_q, any_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic               coll_q, coll_d;
  edge_code_t         code_out_q, code_out_d;
  logic [COUNT_W-1:0] count_out_q, count_out_d;

  smiley_edge_classifier #(
    .OBJECT_WIDTH_X (OBJECT_WIDTH_X),
    .OBJECT_HEIGHT_Y(OBJECT_HEIGHT_Y),
    .EDGE_MARGIN    (EDGE_MARGIN)
  ) u_classifier (
    .pixelX                (bus.pixelX),
    .pixelY                (bus.pixelY),
    .topLeftX              (bus.topLeftX),
    .topLeftY              (bus.topLeftY),
    .smileyDrawingRequest  (bus.smileyDrawingRequest),
    .obstacleDrawingRequest(bus.obstacleDrawingRequest),
    .hit                   (hit_s0),
    .code                  (code_s0)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      hit_q       <= 1'b0;
      code_q      <= '0;
      state_q     <= WAIT_SOF;
      acc_q       <= '0;
      any_q       <= 1'b0;
      cnt_q       <= '0;
      coll_q      <= 1'b0;
      code_out_q  <= '0;
      count_out_q <= '0;
    end else begin
      hit_q       <= hit_s0;
      code_q      <= code_s0;
      state_q     <= state_d;
      acc_q       <= acc_d;
      any_q       <= any_d;
      cnt_q       <= cnt_d;
      coll_q      <= coll_d;
      code_out_q  <= code_out_d;
      count_out_q <= count_out_d;
    end
  end

  assign cnt_inc = (hit_q && (cnt_q != CNT_MAX)) ? cnt_q + 1'b1 : cnt_q;

  // The stage-1 sample present on the SOF cycle closes out the ending frame.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    any_d       = any_q;
    cnt_d       = cnt_q;
    coll_d      = 1'b0;
    code_out_d  = code_out_q;
    count_out_d = count_out_q;
    case (state_q)
      WAIT_SOF: begin
        if (bus.startOfFrame) state_d = ACCUM;
      end
      ACCUM: begin
        if (bus.startOfFrame) begin
          coll_d      = any_q | hit_q;
          code_out_d  = acc_q | code_q;
          count_out_d = cnt_inc;
          acc_d       = '0;
          any_d       = 1'b0;
          cnt_d       = '0;
        end else begin
          acc_d = acc_q | code_q;
          any_d = any_q | hit_q;
          cnt_d = cnt_inc;
        end
      end
      default: state_d = WAIT_SOF;
    endcase
  end

  assign bus.collision     = coll_q;
  assign bus.HitEdgeCode   = code_out_q;
  assign bus.hitPixelCount = count_out_q;

endmodule

// File: tb/tb_smiley_hit_edge_detector.sv
// Directed bench for smiley_hit_edge_detector: per-frame reports with hand-computed expectations.
module tb_smiley_hit_edge_detector;
  import smiley_collision_pkg::*;

  logic clk;
  logic resetN;
  int   errors;
  int   checks;

  smiley_hit_edge_detector_if #(.COUNT_W(8)) bus ();

  smiley_hit_edge_detector #(
    .OBJECT_WIDTH_X (64),
    .OBJECT_HEIGHT_Y(64),
    .EDGE_MARGIN    (8),
    .COUNT_W        (8)
  ) dut (
    .clk   (clk),
    .resetN(resetN),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.smileyDrawingRequest   = 1'b0;
    bus.obstacleDrawingRequest = 1'b0;
    bus.startOfFrame           = 1'b0;
  endtask

  task automatic pix(input int x, input int y, input logic sm, input logic ob);
    bus.pixelX                 = 11'(x);
    bus.pixelY                 = 11'(y);
    bus.smileyDrawingRequest   = sm;
    bus.obstacleDrawingRequest = ob;
    tick();
    idle();
  endtask

  // SOF pulse; on return we sit #1 after the edge that produced the report.
  task automatic sof();
    bus.startOfFrame = 1'b1;
    tick();
    bus.startOfFrame = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    bus.pixelX = '0; bus.pixelY = '0;
    bus.topLeftX = 11'sd100; bus.topLeftY = 11'sd100;
    resetN = 1'b0;
    repeat (3) tick();
    checks++; if (bus.collision !== 1'b0) begin errors++; $display("FAIL reset_coll got=%b exp=0", bus.collision); end
    checks++; if (bus.HitEdgeCode !== 4'b0000) begin errors++; $display("FAIL reset_code got=%b exp=0000", bus.HitEdgeCode); end
    checks++; if (bus.hitPixelCount !== 8'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", bus.hitPixelCount); end
    resetN = 1'b1;
    tick();
    pix(102, 130, 1, 1);
    pix(163, 163, 1, 1);
    sof();
    checks++; if (bus.collision !== 1'b0) begin errors++; $display("FAIL first_sof_coll got=%b exp=0", bus.collision); end
    checks++; if (bus.HitEdgeCode !== 4'b0000) begin errors++; $display("FAIL first_sof_code got=%b exp=0000", bus.HitEdgeCode); end
    checks++; if (bus.hitPixelCount !== 8'd0) begin errors++; $display("FAIL first_sof_count got=%0d exp=0", bus.hitPixelCount); end
    tick();
  endtask

  task automatic test_left_edge();
    pix(102, 130, 1, 1);
    tick();
    sof();
    checks++; if (bus.collision !== 1'b1) begin errors++; $display("FAIL left_coll got=%b exp=1", bus.collision); end
    checks++; if (bus.HitEdgeCode !== 4'b1000) begin errors++; $display("FAIL left_code got=%b exp=1000", bus.HitEdgeCode); end
    checks++; if (bus.hitPixelCount !== 8'd1) begin errors++; $display("FAIL left_count got=%0d exp=1", bus.hitPixelCount); end
    tick();
    checks++; if (bus.collision !== 1'b0) begin errors++; $display("FAIL left_pulse_width got=%b exp=0", bus.collision); end
  endtask

  task automatic test_corner();
    pix(163, 163, 1, 1);
    pix(130, 101, 1, 1);
    tick();
    checks++; if (bus.HitEdgeCode !== 4'b1000) begin errors++; $display("FAIL corner_hold_code got=%b exp=1000", bus.HitEdgeCode); end
    checks++; if (bus.hitPixelCount !== 8'd1) begin errors++; $display("FAIL corner_hold_count got=%0d exp=1", bus.hitPixelCount); end
    sof();
    checks++; if (bus.collision !== 1'b1) begin errors++; $display("FAIL corner_coll got=%b exp=1", bus.collision); end
    checks++; if (bus.HitEdgeCode !== 4'b0111) begin errors++; $display("FAIL corner_code got=%b exp=0111", bus.HitEdgeCode); end
    checks++; if (bus.hitPixelCount !== 8'd2) begin errors++; $display("FAIL corner_count got=%0d exp=2", bus.hitPixelCount); end
    tick();
  endtask

  task automatic test_centre();
    pix(132, 132, 1, 1);
    pix(140, 140, 1, 0);
    sof();
    checks++; if (bus.collision !== 1'b1) begin errors++; $display("FAIL centre_coll got=%b exp=1", bus.collision); end
    checks++; if (bus.HitEdgeCode !== 4'b0000) begin errors++; $display("FAIL centre_code got=%b exp=0000", bus.HitEdgeCode); end
    checks++; if (bus.hitPixelCount !== 8'd1) begin errors++; $display("FAIL centre_count got=%0d exp=1", bus.hitPixelCount); end
    tick();
  endtask

  // Smiley partly off-screen; (60,40) has offX=70 (outside) with offY=60 that would be Bottom if not masked.
  task automatic test_negative_origin();
    bus.topLeftX = -11'sd10; bus.topLeftY = -11'sd20;
    pix(0, 0, 1, 1);
    pix(60, 40, 0, 1);
    pix(60, 40, 1, 1);
    sof();
    checks++; if (bus.collision !== 1'b1) begin errors++; $display("FAIL neg_coll got=%b exp=1", bus.collision); end
    checks++; if (bus.HitEdgeCode !== 4'b0000) begin errors++; $display("FAIL neg_code got=%b exp=0000", bus.HitEdgeCode); end
    checks++; if (bus.hitPixelCount !== 8'd2) begin errors++; $display("FAIL neg_count got=%0d exp=2", bus.hitPixelCount); end
    bus.topLeftX = 11'sd100; bus.topLeftY = 11'sd100;
    tick();
  endtask

  task automatic test_empty_frame();
    pix(102, 130, 0, 1);
    pix(102, 130, 1, 0);
    sof();
    checks++; if (bus.collision !== 1'b0) begin errors++; $display("FAIL empty_coll got=%b exp=0", bus.collision); end
    checks++; if (bus.HitEdgeCode !== 4'b0000) begin errors++; $display("FAIL empty_code got=%b exp=0000", bus.HitEdgeCode); end
    checks++; if (bus.hitPixelCount !== 8'd0) begin errors++; $display("FAIL empty_count got=%0d exp=0", bus.hitPixelCount); end
    tick();
  endtask

  task automatic test_saturation();
    bus.pixelX = 11'd102; bus.pixelY = 11'd130;
    bus.smileyDrawingRequest = 1'b1; bus.obstacleDrawingRequest = 1'b1;
    for (int i = 0; i < 300; i++) tick();
    idle();
    sof();
    checks++; if (bus.collision !== 1'b1) begin errors++; $display("FAIL sat_coll got=%b exp=1", bus.collision); end
    checks++; if (bus.HitEdgeCode !== 4'b1000) begin errors++; $display("FAIL sat_code got=%b exp=1000", bus.HitEdgeCode); end
    checks++; if (bus.hitPixelCount !== 8'd255) begin errors++; $display("FAIL sat_count got=%0d exp=255", bus.hitPixelCount); end
    tick();
  endtask

  // Top-band hit right before SOF belongs to the old frame; bottom-band hit on SOF belongs to the new one.
  task automatic test_frame_boundary();
    pix(130, 101, 1, 1);
    bus.pixelX = 11'd130; bus.pixelY = 11'd163;
    bus.smileyDrawingRequest = 1'b1; bus.obstacleDrawingRequest = 1'b1;
    sof();
    idle();
    checks++; if (bus.collision !== 1'b1) begin errors++; $display("FAIL bound_old_coll got=%b exp=1", bus.collision); end
    checks++; if (bus.HitEdgeCode !== 4'b0100) begin errors++; $display("FAIL bound_old_code got=%b exp=0100", bus.HitEdgeCode); end
    checks++; if (bus.hitPixelCount !== 8'd1) begin errors++; $display("FAIL bound_old_count got=%0d exp=1", bus.hitPixelCount); end
    tick();
    sof();
    checks++; if (bus.collision !== 1'b1) begin errors++; $display("FAIL bound_new_coll got=%b exp=1", bus.collision); end
    checks++; if (bus.HitEdgeCode !== 4'b0001) begin errors++; $display("FAIL bound_new_code got=%b exp=0001", bus.HitEdgeCode); end
    checks++; if (bus.hitPixelCount !== 8'd1) begin errors++; $display("FAIL bound_new_count got=%0d exp=1", bus.hitPixelCount); end
    tick();
  endtask

  task automatic test_back_to_back();
    pix(163, 130, 1, 1);
    bus.startOfFrame = 1'b1;
    tick();
    checks++; if (bus.collision !== 1'b1) begin errors++; $display("FAIL b2b_first_coll got=%b exp=1", bus.collision); end
    checks++; if (bus.HitEdgeCode !== 4'b0010) begin errors++; $display("FAIL b2b_first_code got=%b exp=0010", bus.HitEdgeCode); end
    tick();
    bus.startOfFrame = 1'b0;
    checks++; if (bus.collision !== 1'b0) begin errors++; $display("FAIL b2b_second_coll got=%b exp=0", bus.collision); end
    checks++; if (bus.HitEdgeCode !== 4'b0000) begin errors++; $display("FAIL b2b_second_code got=%b exp=0000", bus.HitEdgeCode); end
    checks++; if (bus.hitPixelCount !== 8'd0) begin errors++; $display("FAIL b2b_second_count got=%0d exp=0", bus.hitPixelCount); end
    tick();
  endtask

  task automatic test_mid_reset();
    pix(102, 101, 1, 1);
    sof();
    checks++; if (bus.HitEdgeCode !== 4'b1100) begin errors++; $display("FAIL pre_rst_code got=%b exp=1100", bus.HitEdgeCode); end
    pix(102, 130, 1, 1);
    pix(102, 130, 1, 1);
    #2 resetN = 1'b0;
    #1;
    checks++; if (bus.HitEdgeCode !== 4'b0000) begin errors++; $display("FAIL midrst_code got=%b exp=0000", bus.HitEdgeCode); end
    checks++; if (bus.hitPixelCount !== 8'd0) begin errors++; $display("FAIL midrst_count got=%0d exp=0", bus.hitPixelCount); end
    tick();
    resetN = 1'b1;
    pix(102, 130, 1, 1);
    sof();
    checks++; if (bus.collision !== 1'b0) begin errors++; $display("FAIL post_rst_coll got=%b exp=0", bus.collision); end
    checks++; if (bus.hitPixelCount !== 8'd0) begin errors++; $display("FAIL post_rst_count got=%0d exp=0", bus.hitPixelCount); end
    tick();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_left_edge();
    test_corner();
    test_centre();
    test_negative_origin();
    test_empty_frame();
    test_saturation();
    test_frame_boundary();
    test_back_to_back();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
